// File: rtl/led_fader_pkg.sv
// Shared types and constant helpers for the LED fader; no logic, no latency, no flow control.
// Channel state names plus PWM_MAX / STEP_DIV derivations used to size counters.
package led_fader_pkg;

  typedef enum logic [1:0] {
    CH_OFF       = 2'd0,
    CH_RAMP_UP   = 2'd1,
    CH_ON        = 2'd2,
    CH_RAMP_DOWN = 2'd3
  } ch_state_e;

  function automatic int pwm_max_f(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

  function automatic int step_div_f(input int clk_freq, input int step_hz);
    return clk_freq / step_hz;
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED: brightness level ramps toward its target on each tick; pwm is registered (1 cycle).
// No backpressure. LED_FADER_GAMMA_EN selects square-law duty instead of linear.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                target,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm,
  output logic                mismatch
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'(pwm_max_f(PWM_BITS));
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] duty;
  ch_state_e           state;

  always_comb begin
    state = CH_OFF;
    if (target) begin
      state = (level == PWM_MAX) ? CH_ON : CH_RAMP_UP;
    end else begin
      state = (level == '0) ? CH_OFF : CH_RAMP_DOWN;
    end
  end

  // Ramp states only exist strictly inside the range, so +/-1 can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (!enable) begin
      level <= '0;
    end else if (tick) begin
      case (state)
        CH_RAMP_UP:   level <= level + LVL_ONE;
        CH_RAMP_DOWN: level <= level - LVL_ONE;
        default:      level <= level;
      endcase
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_w;
  logic [2*PWM_BITS-1:0] level_sq;

  assign level_w  = {{PWM_BITS{1'b0}}, level};
  assign level_sq = level_w * level_w;
  // Truncated square never reaches full scale, so pin the top level to fully on.
  assign duty     = (level == PWM_MAX) ? PWM_MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= enable && (duty > pwm_cnt);
    end
  end

  assign mismatch = (level != (target ? PWM_MAX : '0));

endmodule

// File: rtl/led_fader.sv
// PWM fader for the pattern generator's LED bus; pattern_in -> pattern_q adds 1 cycle, pwm_out/busy registered.
// No backpressure; enable low darkens all LEDs on the next edge. Optional LED_FADER_GAMMA_EN square-law duty.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_HZ  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] pwm_out,
  output logic                busy
);

  localparam int STEP_DIV = step_div_f(CLK_FREQ, STEP_HZ);
  localparam int PS_W     = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_DIV - 1);
  localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(pwm_max_f(PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] mismatch;
  logic                tick;

  assign tick = enable && (prescaler == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (!enable || prescaler == PS_LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PS_ONE;
    end
  end

  // Period is PWM_MAX cycles so that duty PWM_MAX compares high on every count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (!enable || pwm_cnt == CNT_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_in;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .target   (pattern_q[i]),
      .enable   (enable),
      .pwm_cnt  (pwm_cnt),
      .pwm      (pwm_out[i]),
      .mismatch (mismatch[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= enable && (|mismatch);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: per-cycle scoreboard against a time-based reference plus vector table and corner sequences.
module tb_led_fader;
  import led_fader_pkg::*;

  localparam int NUM_LEDS = 8;
  localparam int PWM_BITS = 4;
  localparam int PWM_MAX  = 15;
  localparam int STEP_DIV = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NUM_LEDS-1:0] pattern_in = '0;
  logic                enable = 1'b0;
  logic [NUM_LEDS-1:0] pwm_out;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  led_fader #(
    .CLK_FREQ (1000),
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (PWM_BITS),
    .STEP_HZ  (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pattern_in (pattern_in),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: m_run counts edges since enable last came up; the step and PWM
  // phases are simply that count modulo STEP_DIV and PWM_MAX.
  int                  m_run;
  int                  m_lvl [NUM_LEDS];
  logic [NUM_LEDS-1:0] m_pq;
  logic [NUM_LEDS-1:0] m_pwm;
  logic                m_busy;

  function automatic int duty_of(input int lvl);
`ifdef LED_FADER_GAMMA_EN
    if (lvl == PWM_MAX) return PWM_MAX;
    return (lvl * lvl) / (PWM_MAX + 1);
`else
    return lvl;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  <= 0;
      m_pq   <= '0;
      m_pwm  <= '0;
      m_busy <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) m_lvl[i] <= 0;
    end else begin
      m_run  <= enable ? m_run + 1 : 0;
      m_pq   <= pattern_in;
      m_busy <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        m_pwm[i] <= enable && (duty_of(m_lvl[i]) > (m_run % PWM_MAX));
        if (enable && m_lvl[i] != (m_pq[i] ? PWM_MAX : 0)) m_busy <= 1'b1;
        if (!enable) begin
          m_lvl[i] <= 0;
        end else if ((m_run % STEP_DIV) == STEP_DIV - 1) begin
          if (m_pq[i]) m_lvl[i] <= (m_lvl[i] < PWM_MAX) ? m_lvl[i] + 1 : PWM_MAX;
          else         m_lvl[i] <= (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("pwm_vs_model", 32'(pwm_out), 32'(m_pwm));
    check("busy_vs_model", 32'(busy), 32'(m_busy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NUM_LEDS-1:0] pat;
    logic                en;
    int                  cycles;
    logic [NUM_LEDS-1:0] exp_pwm;
    logic [NUM_LEDS-1:0] pwm_mask;
    logic                exp_busy;
  } vec_t;

  vec_t vecs [7];
  int   nsteps;
  logic seen;
  logic all_ok;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1000, 8'h00, 8'hFF, 1'b0};
    vecs[1] = '{8'h01, 1'b1,  200, 8'h01, 8'hFF, 1'b0};
    vecs[2] = '{8'hFF, 1'b1,  200, 8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{8'hFF, 1'b0,    3, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{8'h0F, 1'b1,  200, 8'h0F, 8'hFF, 1'b0};
    vecs[5] = '{8'hF0, 1'b1,    3, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{8'hF0, 1'b1,  200, 8'hF0, 8'hFF, 1'b0};

    #1 rst = 1'b1;
    #1;
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int v = 0; v < 7; v++) begin
      pattern_in = vecs[v].pat;
      enable     = vecs[v].en;
      for (int c = 0; c < vecs[v].cycles; c++) step();
      check($sformatf("vec%0d_pwm", v), 32'(pwm_out & vecs[v].pwm_mask),
            32'(vecs[v].exp_pwm & vecs[v].pwm_mask));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Reversal mid-ramp: 7 ticks up, then down from level 7 with no jump
    do_reset();
    pattern_in = 8'h01;
    enable     = 1'b1;
    for (int c = 0; c < 72; c++) step();
    check("rev_busy_up", 32'(busy), 32'h1);
    pattern_in = 8'h00;
    nsteps = 0;
    seen   = 1'b0;
    while (!seen && nsteps < 200) begin
      step();
      nsteps++;
      if (!busy) seen = 1'b1;
    end
    check("rev_busy_fell", 32'(seen), 32'h1);
    check("rev_down_cycles", 32'(nsteps), 32'd69);

    // Enable drop after 9 ticks, then full re-ramp from zero
    do_reset();
    pattern_in = 8'hFF;
    for (int c = 0; c < 92; c++) step();
    enable = 1'b0;
    step();
    check("dis_pwm", 32'(pwm_out), 32'h0);
    check("dis_busy", 32'(busy), 32'h0);
    step();
    enable = 1'b1;
    for (int c = 0; c < 150; c++) step();
    check("reen_busy_at_150", 32'(busy), 32'h1);
    step();
    check("reen_busy_done", 32'(busy), 32'h0);
    all_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (pwm_out !== 8'hFF) all_ok = 1'b0;
    end
    check("full_on_steady", 32'(all_ok), 32'h1);

    // Async reset mid-ramp, then outputs dark until the first tick has effect
    pattern_in = 8'hA5;
    for (int c = 0; c < 40; c++) step();
    do_reset();
    pattern_in = 8'hFF;
    all_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (pwm_out !== 8'h00) all_ok = 1'b0;
    end
    check("post_rst_dark", 32'(all_ok), 32'h1);

    // Randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39, 0) == 0) pattern_in = NUM_LEDS'($urandom);
      if (!enable) enable = ($urandom_range(3, 0) == 0);
      else if ($urandom_range(499, 0) == 0) enable = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
